// File: rtl/l2cache_mem_bridge_if.sv
// AXI4 master-side bus (AR/R/AW/W/B) between the L2 memory bridge and memory.
// Latency: none, wires only.
// Backpressure: plain AXI valid/ready on every channel.
//   master: the bridge (drives AR/AW/W valids, R/B readies)
//   slave : the memory side (drives readies, R/B payloads)
interface l2cache_mem_bridge_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rresp;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rlast, rresp,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rlast, rresp,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/l2cache_mem_bridge.sv
// Converts the L2 req/addrOK/dataOK memory handshake into AXI4 INCR bursts, with a one-entry write buffer.
// Latency: addrOK same cycle as request; read dataOK one cycle after the last R beat (if rdy).
// Backpressure: AXI valids hold until ready; L2 requests held while the write buffer is busy or a RAW hazard exists.
//   Ports: clk, rst (sync, active high); L2 side req_r/req_w/rdy/suc/addr_r/addr_w/wdata/wstrb in,
//   addrOK_r/addrOK_w/dataOK/rdata out; axi = AXI4 master bus.
module l2cache_mem_bridge #(
    parameter int unsigned offset_width = 2,
    parameter logic [3:0]  axi_id       = 4'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           l2cache_mem_req_r,
    input  logic                           l2cache_mem_req_w,
    input  logic                           l2cache_mem_rdy,
    input  logic                           l2cache_mem_suc,
    input  logic [31:0]                    l2cache_mem_addr_r,
    input  logic [31:0]                    l2cache_mem_addr_w,
    input  logic [(32<<offset_width)-1:0]  l2cache_mem_wdata,
    input  logic [3:0]                     l2cache_mem_wstrb,
    output logic                           mem_l2cache_addrOK_r,
    output logic                           mem_l2cache_addrOK_w,
    output logic                           mem_l2cache_dataOK,
    output logic [(32<<offset_width)-1:0]  mem_l2cache_rdata,
    l2cache_mem_bridge_if.master           axi
);
    localparam int unsigned WORDS = 1 << offset_width;
    localparam int unsigned LB    = 2 + offset_width;
    localparam logic [7:0]  LINE_LEN = 8'(WORDS - 1);
    localparam logic [offset_width-1:0] CNT_ONE = offset_width'(1);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    // write buffer
    logic [31:0]             wb_addr;
    logic [WORDS-1:0][31:0]  wb_line;
    logic [3:0]              wb_strb;
    logic                    wb_suc;
    logic [offset_width-1:0] wcnt;
    logic                    awvalid_q, wvalid_q, bready_q;
    logic                    w_last;

    // read side
    logic [31:0]             rd_addr;
    logic                    rd_suc;
    logic [offset_width-1:0] rcnt;
    logic [WORDS-1:0][31:0]  rd_line, rd_next, rdata_q;
    logic                    arvalid_q, rready_q;

    // RAW hazard: compare against the buffered write, or against a write being
    // captured this very cycle, so the write always lands first in memory order.
    logic        wb_busy, hz_vld, hz_suc, raw_hazard;
    logic [31:2] hz_addr;

    always_comb begin
        wb_busy = (wstate != W_IDLE);
        hz_vld  = wb_busy | l2cache_mem_req_w;
        hz_addr = wb_busy ? wb_addr[31:2] : l2cache_mem_addr_w[31:2];
        hz_suc  = wb_busy ? wb_suc : l2cache_mem_suc;
        // Word granularity only when both sides are single-word; otherwise a
        // line overlap is enough to order the read behind the write.
        if (l2cache_mem_suc && hz_suc)
            raw_hazard = hz_vld && (l2cache_mem_addr_r[31:2] == hz_addr[31:2]);
        else
            raw_hazard = hz_vld && (l2cache_mem_addr_r[31:LB] == hz_addr[31:LB]);
    end

    assign mem_l2cache_addrOK_w = (wstate == W_IDLE) && l2cache_mem_req_w;
    assign mem_l2cache_addrOK_r = (rstate == R_IDLE) && l2cache_mem_req_r && !raw_hazard;
    assign mem_l2cache_dataOK   = (rstate == R_DONE) && l2cache_mem_rdy;
    assign mem_l2cache_rdata    = rdata_q;

    assign w_last = wvalid_q && (wb_suc || (&wcnt));

    // Line being assembled including the beat on the bus; single-word reads
    // clear the rest of the line so only [31:0] carries data.
    always_comb begin
        rd_next = rd_suc ? '0 : rd_line;
        rd_next[rcnt] = axi.rdata;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate    <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wcnt      <= '0;
            wb_addr   <= '0;
            wb_line   <= '0;
            wb_strb   <= '0;
            wb_suc    <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (l2cache_mem_req_w) begin
                    wb_addr   <= l2cache_mem_addr_w;
                    wb_line   <= l2cache_mem_wdata;
                    wb_strb   <= l2cache_mem_suc ? l2cache_mem_wstrb : 4'hF;
                    wb_suc    <= l2cache_mem_suc;
                    awvalid_q <= 1'b1;
                    wstate    <= W_AW;
                end
                W_AW: if (axi.awready) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    wcnt      <= '0;
                    wstate    <= W_DATA;
                end
                W_DATA: if (axi.wready) begin
                    if (w_last) begin
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        wstate   <= W_RESP;
                    end else begin
                        wcnt <= wcnt + CNT_ONE;
                    end
                end
                W_RESP: if (axi.bvalid) begin
                    bready_q <= 1'b0;
                    wstate   <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate    <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rcnt      <= '0;
            rd_addr   <= '0;
            rd_suc    <= 1'b0;
            rd_line   <= '0;
            rdata_q   <= '0;
        end else begin
            case (rstate)
                R_IDLE: if (mem_l2cache_addrOK_r) begin
                    rd_addr   <= l2cache_mem_addr_r;
                    rd_suc    <= l2cache_mem_suc;
                    arvalid_q <= 1'b1;
                    rstate    <= R_AR;
                end
                R_AR: if (axi.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    rcnt      <= '0;
                    rstate    <= R_DATA;
                end
                R_DATA: if (axi.rvalid) begin
                    rd_line <= rd_next;
                    if (axi.rlast || rd_suc) begin
                        // Output line only changes here, so it stays stable
                        // through the next read's burst.
                        rdata_q  <= rd_next;
                        rready_q <= 1'b0;
                        rstate   <= R_DONE;
                    end else begin
                        rcnt <= rcnt + CNT_ONE;
                    end
                end
                R_DONE: if (l2cache_mem_rdy) rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // ---------------- AXI drive ----------------
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = rd_addr;
    assign axi.arlen   = rd_suc ? 8'd0 : LINE_LEN;
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;
    assign axi.arid    = axi_id;
    assign axi.rready  = rready_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = wb_addr;
    assign axi.awlen   = wb_suc ? 8'd0 : LINE_LEN;
    assign axi.awsize  = 3'd2;
    assign axi.awburst = 2'b01;
    assign axi.awid    = axi_id;

    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wb_line[wcnt];
    assign axi.wstrb   = wb_strb;
    assign axi.wlast   = w_last;
    assign axi.bready  = bready_q;
endmodule
